// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC/IR front end with a single outstanding imem read,
// a one-word skid buffer for stalls, and squash of in-flight words on redirect.
module instr_fetch_stage #(
    parameter int              INSTR_W  = 28,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               Clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_inc;
    logic [INSTR_W-1:0] skid;
    logic               squash;
    assign pc_inc = pc + 1'b1;
    always_ff @(posedge Clock) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            skid        <= '0;
            squash      <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_out   <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            if (!stall) instr_valid <= 1'b0;
            if (redirect) begin
                pc          <= redirect_pc;
                instr_valid <= 1'b0;
                skid        <= '0;
                // A request issued this cycle, or one still in flight, must be drained before refetching
                if (state == S_REQ || (state == S_WAIT && !imem_valid)) begin
                    squash <= 1'b1;
                    state  <= S_WAIT;
                end else begin
                    squash    <= 1'b0;
                    state     <= S_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= redirect_pc;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        state     <= S_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                    S_REQ: state <= S_WAIT;
                    S_WAIT: begin
                        if (imem_valid && squash) begin
                            squash    <= 1'b0;
                            state     <= S_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end else if (imem_valid && !stall) begin
                            instr_out   <= imem_rdata;
                            pc_out      <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc_inc;
                            state       <= S_REQ;
                            imem_req    <= 1'b1;
                            imem_addr   <= pc_inc;
                        end else if (imem_valid) begin
                            skid  <= imem_rdata;
                            state <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            instr_out   <= skid;
                            pc_out      <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc_inc;
                            state       <= S_REQ;
                            imem_req    <= 1'b1;
                            imem_addr   <= pc_inc;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
